// File: rtl/i2c_burst_sequencer.sv
// i2c_burst_sequencer: turns one burst command into a series of single-byte i2c_master transfers,
// fed from a write FIFO and filling a first-word-fall-through read FIFO.
module i2c_burst_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0]          i_cmd_device_addr,
    input  logic [REG_WIDTH-1:0]           i_cmd_reg_addr,
    input  logic [$clog2(DEPTH+1)-1:0]     i_cmd_len,
    input  logic [15:0]                    i_cmd_divider,
    input  logic                           i_wr_valid,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    output logic                           o_wr_full,
    output logic                           o_rd_valid,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    input  logic                           i_rd_ready,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_timeout,
    output logic                           o_enable,
    output logic                           o_rw,
    output logic [DATA_WIDTH-1:0]          o_mosi_data,
    output logic [REG_WIDTH-1:0]           o_reg_addr,
    output logic [ADDR_WIDTH-1:0]          o_device_addr,
    output logic [15:0]                    o_divider,
    input  logic [DATA_WIDTH-1:0]          i_miso_data,
    input  logic                           i_busy
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CHECK, WAIT_IDLE, ASSERT, WAIT_DONE, CAPTURE, DONE} state_t;

    state_t                state;
    logic [LW-1:0]         remaining, wr_cnt, rd_cnt;
    logic [PW-1:0]         wr_wp, wr_rp, rd_wp, rd_rp;
    logic [TW-1:0]         wait_cnt;
    logic [DATA_WIDTH-1:0] wr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_mem [DEPTH];
    logic                  waiting, advance, tmo, wr_push, wr_pop, rd_push, rd_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ASSERT waits for the master to go busy; the other two wait states wait for it to go idle
    assign waiting     = (state == WAIT_IDLE) || (state == ASSERT) || (state == WAIT_DONE);
    assign advance     = (state == ASSERT) ? i_busy : !i_busy;
    assign tmo         = waiting && !advance && (wait_cnt == TW'(TIMEOUT - 1));
    assign o_wr_full   = wr_cnt == LW'(DEPTH);
    assign o_rd_valid  = rd_cnt != '0;
    assign o_rd_data   = rd_mem[rd_rp];
    assign o_cmd_ready = state == IDLE;
    assign o_busy      = state != IDLE;
    assign wr_push     = i_wr_valid && !o_wr_full;
    assign wr_pop      = (state == WAIT_IDLE) && !i_busy && !o_rw;
    assign rd_push     = (state == CAPTURE) && o_rw;
    assign rd_pop      = i_rd_ready && o_rd_valid;

    always_ff @(posedge i_clk) begin
        if (wr_push) wr_mem[wr_wp] <= i_wr_data;
        if (rd_push) rd_mem[rd_wp] <= i_miso_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            remaining     <= '0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            wr_wp         <= '0;
            wr_rp         <= '0;
            rd_wp         <= '0;
            rd_rp         <= '0;
            wait_cnt      <= '0;
            o_enable      <= 1'b0;
            o_rw          <= 1'b0;
            o_mosi_data   <= '0;
            o_reg_addr    <= '0;
            o_device_addr <= '0;
            o_divider     <= '0;
            o_done        <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            wait_cnt <= (waiting && !advance) ? wait_cnt + TW'(1) : '0;
            if (tmo) begin
                wr_wp  <= '0;
                wr_rp  <= '0;
                wr_cnt <= '0;
            end else begin
                if (wr_push) wr_wp <= nxt(wr_wp);
                if (wr_pop) wr_rp <= nxt(wr_rp);
                wr_cnt <= wr_cnt + LW'(wr_push) - LW'(wr_pop);
            end
            if (rd_push) rd_wp <= nxt(rd_wp);
            if (rd_pop) rd_rp <= nxt(rd_rp);
            rd_cnt <= rd_cnt + LW'(rd_push) - LW'(rd_pop);
            case (state)
                IDLE: if (i_cmd_valid) begin
                    o_rw          <= i_cmd_rw;
                    o_device_addr <= i_cmd_device_addr;
                    o_reg_addr    <= i_cmd_reg_addr;
                    o_divider     <= i_cmd_divider;
                    remaining     <= i_cmd_len;
                    o_timeout     <= 1'b0;
                    state         <= CHECK;
                end
                CHECK: state <= (remaining == '0) ? DONE :
                                ((!o_rw && wr_cnt == '0) || (o_rw && rd_cnt == LW'(DEPTH))) ? CHECK : WAIT_IDLE;
                WAIT_IDLE: if (advance) begin
                    o_enable <= 1'b1;
                    if (!o_rw) o_mosi_data <= wr_mem[wr_rp];
                    state <= ASSERT;
                end
                ASSERT: if (advance) begin
                    o_enable <= 1'b0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: if (advance) state <= CAPTURE;
                CAPTURE: begin
                    remaining  <= remaining - LW'(1);
                    o_reg_addr <= o_reg_addr + REG_WIDTH'(1);
                    state      <= CHECK;
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (tmo) begin
                o_timeout <= 1'b1;
                o_enable  <= 1'b0;
                state     <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// tb_i2c_burst_sequencer: scoreboard bench with a behavioural i2c_master/slave model,
// run with DEPTH=4 and TIMEOUT=16 so FIFO-full and timeout corners are reachable.
module tb_i2c_burst_sequencer;
    typedef logic [23:0] txn_t;

    logic       clk = 0, rst = 1, cmd_valid = 0, cmd_rw = 0, wr_valid = 0, rd_ready = 0;
    logic [6:0] cmd_dev = 0;
    logic [7:0] cmd_reg = 0, wr_data = 0, miso = 0;
    logic [2:0] cmd_len = 0;
    logic [15:0] cmd_div = 0;
    logic       cmd_ready, wr_full, rd_valid, busy, done, timeout, enable, rw;
    logic [7:0] rd_data, mosi, reg_addr;
    logic [6:0] dev_addr;
    logic [15:0] divider;
    logic       m_busy = 0, tie0 = 0, slv_busy;
    int         m_cnt = 0, done_cnt = 0, en_cnt = 0, total = 0, bad = 0;
    logic [7:0] smem [256];
    txn_t       exp_q[$], obs_q[$];
    logic [7:0] rd_exp[$];

    assign slv_busy = m_busy && !tie0;

    i2c_burst_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_rw(cmd_rw), .i_cmd_device_addr(cmd_dev), .i_cmd_reg_addr(cmd_reg),
        .i_cmd_len(cmd_len), .i_cmd_divider(cmd_div), .i_wr_valid(wr_valid),
        .i_wr_data(wr_data), .o_wr_full(wr_full), .o_rd_valid(rd_valid),
        .o_rd_data(rd_data), .i_rd_ready(rd_ready), .o_busy(busy), .o_done(done),
        .o_timeout(timeout), .o_enable(enable), .o_rw(rw), .o_mosi_data(mosi),
        .o_reg_addr(reg_addr), .o_device_addr(dev_addr), .o_divider(divider),
        .i_miso_data(miso), .i_busy(slv_busy)
    );

    always #5 clk = ~clk;

    // i2c_master + slave register file: one transfer per o_enable, busy for a few cycles
    always @(negedge clk) begin
        if (rst) begin
            m_busy <= 0;
            m_cnt  <= 0;
        end else if (!tie0) begin
            if (!m_busy && enable) begin
                m_busy <= 1;
                m_cnt  <= 3;
                obs_q.push_back({rw, dev_addr, reg_addr, rw ? 8'h00 : mosi});
                if (rw) miso <= smem[reg_addr];
                else smem[reg_addr] <= mosi;
            end else if (m_busy) begin
                if (m_cnt == 0) m_busy <= 0;
                else m_cnt <= m_cnt - 1;
            end
        end
        if (done) done_cnt++;
        if (enable) en_cnt++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] d);
        wr_valid = 1;
        wr_data  = d;
        tick();
        wr_valid = 0;
    endtask

    task automatic issue_cmd(input logic r, input logic [6:0] dev, input logic [7:0] rg, input logic [2:0] len);
        cmd_rw = r; cmd_dev = dev; cmd_reg = rg; cmd_len = len; cmd_div = 16'hFFFF;
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int start = done_cnt;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = done_cnt != start;
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total++;
        if ({busy, enable, done, timeout, rd_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_held flags got=%b exp=00000", {busy, enable, done, timeout, rd_valid});
        end
        rst = 0;
        tick();
        total++;
        if ({cmd_ready, busy, done, timeout, rd_valid, wr_full, enable, rw} !== 8'b1000_0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=10000000", {cmd_ready, busy, done, timeout, rd_valid, wr_full, enable, rw});
        end
        total++;
        if ({reg_addr, dev_addr, mosi, divider} !== 39'd0) begin
            bad++; $display("FAIL reset_regs got=%h exp=0", {reg_addr, dev_addr, mosi, divider});
        end
    endtask

    task automatic test_write_burst;
        logic [7:0] bytes [3] = '{8'hDC, 8'hA5, 8'h3C};
        logic ok;
        int start = done_cnt;
        txn_t got, want;
        for (int i = 0; i < 3; i++) begin
            push_wr(bytes[i]);
            exp_q.push_back({1'b0, 7'h11, 8'(i), bytes[i]});
        end
        issue_cmd(0, 7'h11, 8'h00, 3);
        total++;
        if (enable !== 1'b0 || divider !== 16'hFFFF) begin
            bad++; $display("FAIL wr_accept enable=%b divider=%h exp 0/ffff", enable, divider);
        end
        tick();
        tick();
        total++;
        if (enable !== 1'b1) begin bad++; $display("FAIL wr_latency enable got=%b exp=1", enable); end
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wr_done_wait got=none exp=pulse"); end
        for (int i = 0; i < 3; i++) begin
            total++;
            want = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL wr_txn%0d got=none exp=%h", i, want);
            end else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL wr_txn%0d got=%h exp=%h", i, got, want); end
            end
        end
        repeat (3) tick();
        total++;
        if (done_cnt - start != 1 || timeout !== 1'b0 || obs_q.size() != 0) begin
            bad++; $display("FAIL wr_end dones=%0d timeout=%b extra=%0d exp 1/0/0", done_cnt - start, timeout, obs_q.size());
        end
    endtask

    task automatic test_read_burst(input logic [7:0] rg, input int len, input logic [31:0] bytes);
        logic ok;
        int start = done_cnt;
        txn_t got, want;
        logic [7:0] w;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b1, 7'h11, 8'(rg + 8'(i)), 8'h00});
            rd_exp.push_back(bytes[8*i +: 8]);
        end
        issue_cmd(1, 7'h11, rg, 3'(len));
        wait_done(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd_done_wait reg=%h got=none exp=pulse", rg); end
        for (int i = 0; i < len; i++) begin
            total++;
            want = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL rd_txn%0d got=none exp=%h", i, want);
            end else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL rd_txn%0d got=%h exp=%h", i, got, want); end
            end
        end
        for (int i = 0; i < len; i++) begin
            w = rd_exp.pop_front();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== w) begin
                bad++; $display("FAIL rd_data%0d valid=%b got=%h exp=%h", i, rd_valid, rd_data, w);
            end
            rd_ready = 1;
            tick();
            rd_ready = 0;
        end
        total++;
        if (rd_valid !== 1'b0 || done_cnt - start != 1) begin
            bad++; $display("FAIL rd_end valid=%b dones=%0d exp 0/1", rd_valid, done_cnt - start);
        end
    endtask

    task automatic test_len0;
        int en0 = en_cnt;
        logic [2:0] seen;
        issue_cmd(0, 7'h11, 8'h40, 0);
        seen[0] = done;
        tick();
        seen[1] = done;
        tick();
        seen[2] = done;
        tick();
        total++;
        if (seen !== 3'b100 || done !== 1'b0) begin
            bad++; $display("FAIL len0_done got=%b%b exp=1000", seen, done);
        end
        total++;
        if (en_cnt != en0 || reg_addr !== 8'h40) begin
            bad++; $display("FAIL len0_noxfer enables=%0d reg=%h exp 0/40", en_cnt - en0, reg_addr);
        end
    endtask

    task automatic test_timeout;
        int start = done_cnt, hi = 0;
        tie0 = 1;
        push_wr(8'h5A);
        issue_cmd(0, 7'h11, 8'h10, 1);
        for (int i = 0; i < 100 && done_cnt == start; i++) begin
            tick();
            if (enable) hi++;
        end
        total++;
        if (hi != 16) begin bad++; $display("FAIL tmo_enable_cycles got=%0d exp=16", hi); end
        total++;
        if (timeout !== 1'b1 || done_cnt - start != 1 || enable !== 1'b0) begin
            bad++; $display("FAIL tmo_flags timeout=%b dones=%0d enable=%b exp 1/1/0", timeout, done_cnt - start, enable);
        end
        tie0 = 0;
        push_wr(8'h11); push_wr(8'h22); push_wr(8'h33);
        total++;
        if (wr_full !== 1'b0) begin bad++; $display("FAIL tmo_flush full_after3 got=%b exp=0", wr_full); end
        push_wr(8'h44);
        total++;
        if (wr_full !== 1'b1) begin bad++; $display("FAIL tmo_flush full_after4 got=%b exp=1", wr_full); end
    endtask

    task automatic test_fifo_full_reset;
        logic ok;
        int start;
        txn_t got, want;
        push_wr(8'h55);
        total++;
        if (wr_full !== 1'b1) begin bad++; $display("FAIL full_hold got=%b exp=1", wr_full); end
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 7'h11, 8'(8'h20 + 8'(i)), 8'(8'h11 * (i + 1))});
        issue_cmd(0, 7'h11, 8'h20, 4);
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", timeout); end
        wait_done(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_wr_done got=none exp=pulse"); end
        for (int i = 0; i < 4; i++) begin
            total++;
            want = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL full_txn%0d got=none exp=%h", i, want);
            end else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL full_txn%0d got=%h exp=%h", i, got, want); end
            end
        end
        total++;
        if (wr_full !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", wr_full); end
        issue_cmd(1, 7'h11, 8'h20, 1);
        wait_done(300, ok);
        void'(obs_q.pop_front());
        start = done_cnt;
        issue_cmd(1, 7'h11, 8'h20, 4);
        for (int i = 0; i < 300 && obs_q.size() < 3; i++) tick();
        repeat (40) tick();
        cmd_dev = 7'h2A;
        cmd_valid = 1;
        repeat (3) tick();
        cmd_valid = 0;
        total++;
        if (obs_q.size() != 3 || {busy, cmd_ready, enable, rd_valid} !== 4'b1001 || done_cnt != start) begin
            bad++; $display("FAIL stall txns=%0d flags=%b dones=%0d exp 3/1001/0", obs_q.size(), {busy, cmd_ready, enable, rd_valid}, done_cnt - start);
        end
        total++;
        if (dev_addr !== 7'h11) begin bad++; $display("FAIL busy_reject dev got=%h exp=11", dev_addr); end
        for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
            total++;
            got = obs_q.pop_front();
            if (got !== {1'b1, 7'h11, 8'(8'h20 + 8'(i)), 8'h00}) begin
                bad++; $display("FAIL stall_txn%0d got=%h exp=%h", i, got, {1'b1, 7'h11, 8'(8'h20 + 8'(i)), 8'h00});
            end
        end
        rst = 1;
        #1;
        total++;
        if ({busy, done, timeout, rd_valid, wr_full, enable, rw} !== 7'b0 || {reg_addr, dev_addr, mosi, divider} !== 39'd0) begin
            bad++; $display("FAIL async_reset flags=%b regs=%h exp 0/0", {busy, done, timeout, rd_valid, wr_full, enable, rw}, {reg_addr, dev_addr, mosi, divider});
        end
        repeat (2) tick();
        rst = 0;
        repeat (4) tick();
        total++;
        if (done_cnt != start || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset dones=%0d ready=%b rd_valid=%b exp 0/1/0", done_cnt - start, cmd_ready, rd_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) smem[i] = 8'h00;
        smem[255] = 8'h77;
        test_reset();
        test_write_burst();
        test_read_burst(8'h00, 3, 32'h003CA5DC);
        test_read_burst(8'hFF, 2, 32'h0000DC77);
        test_len0();
        test_timeout();
        test_fifo_full_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/i2c_burst_sequencer.md
I2C_BURST_SEQUENCER -- requirements
Module: i2c_burst_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, I2C data byte width.
REQ-002 SHALL have parameter REG_WIDTH, default 8, slave register address width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, slave device address width.
REQ-004 SHALL have parameter DEPTH, default 16, entries in each of the write and read FIFOs and maximum burst length.
REQ-005 SHALL have parameter TIMEOUT, default 1048576, maximum i_clk cycles per handshake wait.
REQ-006 SHALL have ports, one per line:
- i_clk  in  1  single clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_rw  in  1  0 = write burst, 1 = read burst.
- i_cmd_device_addr  in  ADDR_WIDTH  slave address.
- i_cmd_reg_addr  in  REG_WIDTH  first register.
- i_cmd_len  in  $clog2(DEPTH+1)  bytes in burst.
- i_cmd_divider  in  16  SCL divider.
- i_wr_valid  in  1  write-FIFO push.
- i_wr_data  in  DATA_WIDTH  push data.
- o_wr_full  out  1  write FIFO full.
- o_rd_valid  out  1  read FIFO not empty.
- o_rd_data  out  DATA_WIDTH  read FIFO head, first-word-fall-through.
- i_rd_ready  in  1  read-FIFO pop.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse at burst end.
- o_timeout  out  1  sticky error, cleared on next command accept.
- o_enable, o_rw, o_mosi_data, o_reg_addr, o_device_addr, o_divider  out  1/1/DATA_WIDTH/REG_WIDTH/ADDR_WIDTH/16  drive i2c_master.
- i_miso_data  in  DATA_WIDTH  from i2c_master.
- i_busy  in  1  from i2c_master.

Function
REQ-007 SHALL accept a command on the cycle where i_cmd_valid && o_cmd_ready.
- On accept, SHALL latch rw, device_addr, reg_addr, len and divider into the o_* registers and a remaining-byte counter.
REQ-008 SHALL implement FSM states IDLE, CHECK, WAIT_IDLE, ASSERT, WAIT_DONE, CAPTURE, DONE.
REQ-009 IDLE: on accept, SHALL go to CHECK.
REQ-010 CHECK: if remaining==0, SHALL go to DONE.
- Write burst with write FIFO empty: SHALL stall in CHECK.
- Read burst with read FIFO full: SHALL stall in CHECK.
- Otherwise SHALL go to WAIT_IDLE.
REQ-011 WAIT_IDLE: when i_busy==0, SHALL set o_enable=1 and go to ASSERT.
- For a write, SHALL pop the write FIFO into o_mosi_data on the same cycle.
REQ-012 ASSERT: SHALL hold o_enable=1 until i_busy==1, then clear o_enable and go to WAIT_DONE.
REQ-013 WAIT_DONE: when i_busy==0, SHALL go to CAPTURE.
REQ-014 CAPTURE: for a read, SHALL push i_miso_data into the read FIFO.
- In all cases, SHALL decrement remaining, increment o_reg_addr modulo 2^REG_WIDTH, and return to CHECK.
REQ-015 DONE: SHALL pulse o_done for one cycle and return to IDLE.
REQ-016 Each of WAIT_IDLE, ASSERT and WAIT_DONE SHALL count cycles. When the count reaches TIMEOUT, SHALL:
- set o_timeout;
- clear o_enable;
- flush the write FIFO;
- go to DONE.
The read FIFO SHALL be retained.
REQ-017 A push while o_wr_full SHALL be ignored.
- Simultaneous push and pop on a non-full FIFO SHALL both occur, with count unchanged.
REQ-018 A pop while the read FIFO is empty SHALL be ignored.
- A simultaneous CAPTURE push and host pop SHALL both occur.
REQ-019 Command latency: o_enable SHALL rise 2 cycles after accept when i_busy==0 and data is available.
REQ-020 Commands presented while o_busy==1 SHALL NOT be accepted.
- Write-FIFO pushes SHALL be accepted in any state.

Reset
REQ-021 On i_rst high, the block SHALL immediately, without waiting for a clock edge:
- force IDLE;
- empty both FIFOs;
- zero all counters;
- zero o_enable, o_rw, o_mosi_data, o_reg_addr, o_device_addr, o_divider, o_done, o_timeout, o_busy and o_rd_valid;
- set o_cmd_ready=1 after release.
REQ-022 Reset asserted mid-burst SHALL abandon the burst with no o_done pulse.

Verification
REQ-023 Push 0xDC,0xA5,0x3C, then write cmd dev 0x11, reg 0x00, len 3, divider 0xFFFF -> three i2c_master writes to regs 0x00,0x01,0x02 carrying 0xDC,0xA5,0x3C; one o_done; o_timeout=0.
REQ-024 Read cmd dev 0x11, reg 0x00, len 3 against a slave model holding the data above -> o_rd_data sequence 0xDC,0xA5,0x3C; o_done once.
REQ-025 Read cmd with reg 0xFF, len 2 -> o_reg_addr issues 0xFF then 0x00.
REQ-026 Command with len 0 -> o_done 2 cycles after accept; o_enable never asserted.
REQ-027 i_busy tied 0, write len 1, TIMEOUT=16 -> o_enable deasserts after 16 cycles in ASSERT; o_timeout=1; o_done pulses; write FIFO empty.
REQ-028 DEPTH=4, push 5 bytes, then read burst of len 4 without popping, then i_rst pulse mid-burst -> fifth push dropped; o_wr_full=1; FSM stalls in CHECK once the read FIFO is full; reset clears all outputs with no o_done pulse.
